// File: rtl/reu_pkg.sv
// Shared definitions for the REU register file: register indices, transfer
// type encodings, status/mask/command bit positions and the trigger states.
package reu_pkg;

    localparam logic [3:0] REG_STATUS   = 4'h0;
    localparam logic [3:0] REG_CMD      = 4'h1;
    localparam logic [3:0] REG_CA_LO    = 4'h2;
    localparam logic [3:0] REG_CA_HI    = 4'h3;
    localparam logic [3:0] REG_REUA_LO  = 4'h4;
    localparam logic [3:0] REG_REUA_MID = 4'h5;
    localparam logic [3:0] REG_REUA_HI  = 4'h6;
    localparam logic [3:0] REG_LEN_LO   = 4'h7;
    localparam logic [3:0] REG_LEN_HI   = 4'h8;
    localparam logic [3:0] REG_IMASK    = 4'h9;
    localparam logic [3:0] REG_ACTL     = 4'hA;

    localparam logic [1:0] XFER_C64_TO_REU = 2'b00;
    localparam logic [1:0] XFER_REU_TO_C64 = 2'b01;
    localparam logic [1:0] XFER_SWAP       = 2'b10;
    localparam logic [1:0] XFER_VERIFY     = 2'b11;

    localparam int STAT_IRQ  = 7;
    localparam int STAT_EOB  = 6;
    localparam int STAT_VERR = 5;
    localparam int STAT_SIZE = 4;

    localparam int MASK_EN   = 7;
    localparam int MASK_EOB  = 6;
    localparam int MASK_VERR = 5;

    localparam int CMD_EXEC     = 7;
    localparam int CMD_AUTOLOAD = 5;
    localparam int CMD_FF00DIS  = 4;

    localparam int ACTL_FIXCA   = 7;
    localparam int ACTL_FIXREUA = 6;

    typedef enum logic [1:0] {
        TRIG_IDLE,
        TRIG_ARMED,
        TRIG_EXEC
    } trigState_t;

endpackage

// File: rtl/reu_addr_counter.sv
// Loadable transfer counter with a live copy and an autoload shadow. Byte
// writes load both copies; reload copies the shadow back into the live value.
module reu_addr_counter #(
    parameter int W = 16,
    parameter logic [W-1:0] RESETVAL = '0,
    localparam int NBYTES = (W + 7) / 8
) (
    input  logic              PHI2,
    input  logic              RegReset,
    input  logic [NBYTES-1:0] wrEn,
    input  logic [7:0]        wrData,
    input  logic              inc,
    input  logic              dec,
    input  logic              fix,
    input  logic              reload,
    output logic [W-1:0]      count
);

    logic [W-1:0] shadow;
    logic [W-1:0] wrMask;
    logic [W-1:0] wrVal;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign wrMask[i] = wrEn[i / 8];
        assign wrVal[i]  = wrData[i % 8];
    end

    // Reload outranks everything so an autoload end-of-transfer wins over a
    // concurrent step.
    always_ff @(negedge PHI2) begin
        if (RegReset) begin
            count  <= RESETVAL;
            shadow <= '0;
        end else if (reload) begin
            count <= shadow;
        end else if (|wrEn) begin
            count  <= (count & ~wrMask) | (wrVal & wrMask);
            shadow <= (shadow & ~wrMask) | (wrVal & wrMask);
        end else if (inc && !fix) begin
            count <= count + 1'b1;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/reu_regs.sv
// REU register file: $DF00-$DF1F decode, command/status/mask registers,
// transfer trigger and the CA/REUA/length counters feeding the DMA sequencer.
//
// trigger state | meaning
// TRIG_IDLE     | no transfer pending
// TRIG_ARMED    | exec written with FF00 enabled, waiting for a $FF00 write
// TRIG_EXEC     | Execute high until the sequencer raises DMA
module reu_regs
    import reu_pkg::*;
#(
    parameter int REUAW  = 19,
    parameter bit BIGREU = 1'b1
) (
    input  logic             PHI2,
    input  logic             RegReset,
    input  logic             RegCS,
    input  logic [4:0]       RegA,
    input  logic             RegWE,
    input  logic             RegRD,
    input  logic [7:0]       Din,
    output logic [7:0]       Dout,
    input  logic             FF00Wr,
    input  logic             DMA,
    input  logic             IncCA,
    input  logic             DecLen,
    input  logic             IncREUA,
    input  logic             XferEnd,
    input  logic             SetEndOfBlock,
    input  logic             SetVerifyErr,
    output logic             Execute,
    output logic [1:0]       XferType,
    output logic             Length1,
    output logic             Length2,
    output logic [15:0]      CA,
    output logic [REUAW-1:0] REUA,
    output logic             nIRQ
);

    logic [3:0]  idx;
    logic        unusedRegA4;
    logic        wrStb, wrCmd, rdStatus;
    logic        cmdExec, cmdAutoload, cmdFf00Dis;
    logic [1:0]  cmdType;
    logic [2:0]  maskReg;
    logic        fixCa, fixReua;
    logic        statIrq, statEob, statVerr;
    logic        eobNext, verrNext, irqNext;
    logic        reload;
    logic [15:0] len;
    logic [23:0] reuaExt;
    trigState_t  trigState;

    // $DF10-$DF1F mirror the lower half.
    assign idx         = RegA[3:0];
    assign unusedRegA4 = RegA[4];
    assign wrStb       = RegCS && RegWE && !DMA;
    assign wrCmd       = wrStb && (idx == REG_CMD);
    assign rdStatus    = RegCS && RegRD && (idx == REG_STATUS);
    assign reload      = XferEnd && cmdAutoload;

    // A set event on the read edge keeps its flag, and IRQ is judged on the
    // updated flags.
    assign eobNext  = SetEndOfBlock || (statEob && !rdStatus);
    assign verrNext = SetVerifyErr || (statVerr && !rdStatus);
    assign irqNext  = (statIrq && !rdStatus) ||
                      (maskReg[2] && ((eobNext && maskReg[1]) || (verrNext && maskReg[0])));

    always_ff @(negedge PHI2) begin
        if (RegReset) begin
            cmdExec     <= 1'b0;
            cmdAutoload <= 1'b0;
            cmdFf00Dis  <= 1'b1;
            cmdType     <= XFER_C64_TO_REU;
            maskReg     <= 3'b000;
            fixCa       <= 1'b0;
            fixReua     <= 1'b0;
            statIrq     <= 1'b0;
            statEob     <= 1'b0;
            statVerr    <= 1'b0;
        end else begin
            if (wrCmd) begin
                cmdExec     <= Din[CMD_EXEC];
                cmdAutoload <= Din[CMD_AUTOLOAD];
                cmdFf00Dis  <= Din[CMD_FF00DIS];
                cmdType     <= Din[1:0];
            end
            if (XferEnd) begin
                cmdExec    <= 1'b0;
                cmdFf00Dis <= 1'b1;
            end
            if (wrStb && (idx == REG_IMASK))
                maskReg <= {Din[MASK_EN], Din[MASK_EOB], Din[MASK_VERR]};
            if (wrStb && (idx == REG_ACTL)) begin
                fixCa   <= Din[ACTL_FIXCA];
                fixReua <= Din[ACTL_FIXREUA];
            end
            statIrq  <= irqNext;
            statEob  <= eobNext;
            statVerr <= verrNext;
        end
    end

    always_ff @(negedge PHI2) begin
        if (RegReset) begin
            trigState <= TRIG_IDLE;
            Execute   <= 1'b0;
        end else begin
            case (trigState)
                TRIG_IDLE, TRIG_ARMED: begin
                    if (wrCmd) begin
                        if (Din[CMD_EXEC] && Din[CMD_FF00DIS]) begin
                            trigState <= TRIG_EXEC;
                            Execute   <= 1'b1;
                        end else if (Din[CMD_EXEC]) begin
                            trigState <= TRIG_ARMED;
                        end else begin
                            trigState <= TRIG_IDLE;
                        end
                    end else if ((trigState == TRIG_ARMED) && FF00Wr) begin
                        trigState <= TRIG_EXEC;
                        Execute   <= 1'b1;
                    end else if (XferEnd) begin
                        trigState <= TRIG_IDLE;
                    end
                end
                TRIG_EXEC: begin
                    if (DMA) begin
                        trigState <= TRIG_IDLE;
                        Execute   <= 1'b0;
                    end
                end
                default: begin
                    trigState <= TRIG_IDLE;
                    Execute   <= 1'b0;
                end
            endcase
        end
    end

    reu_addr_counter #(.W(16), .RESETVAL(16'h0000)) u_ca (
        .PHI2(PHI2), .RegReset(RegReset),
        .wrEn({wrStb && (idx == REG_CA_HI), wrStb && (idx == REG_CA_LO)}),
        .wrData(Din), .inc(IncCA), .dec(1'b0), .fix(fixCa), .reload(reload),
        .count(CA)
    );

    reu_addr_counter #(.W(REUAW), .RESETVAL('0)) u_reua (
        .PHI2(PHI2), .RegReset(RegReset),
        .wrEn({wrStb && (idx == REG_REUA_HI), wrStb && (idx == REG_REUA_MID),
               wrStb && (idx == REG_REUA_LO)}),
        .wrData(Din), .inc(IncREUA), .dec(1'b0), .fix(fixReua), .reload(reload),
        .count(REUA)
    );

    // Length $0000 stands for 65536, so plain wrap-around decrement is right.
    reu_addr_counter #(.W(16), .RESETVAL(16'hFFFF)) u_len (
        .PHI2(PHI2), .RegReset(RegReset),
        .wrEn({wrStb && (idx == REG_LEN_HI), wrStb && (idx == REG_LEN_LO)}),
        .wrData(Din), .inc(1'b0), .dec(DecLen), .fix(1'b0), .reload(reload),
        .count(len)
    );

    assign Length1  = (len == 16'd1);
    assign Length2  = (len == 16'd2);
    assign XferType = cmdType;
    assign nIRQ     = !statIrq;

    always_comb begin
        reuaExt            = 24'hFFFFFF;
        reuaExt[REUAW-1:0] = REUA;
    end

    always_comb begin
        Dout = 8'hFF;
        case (idx)
            REG_STATUS:   Dout = {statIrq, statEob, statVerr, BIGREU, 4'h0};
            REG_CMD:      Dout = {cmdExec, 1'b1, cmdAutoload, cmdFf00Dis, 2'b11, cmdType};
            REG_CA_LO:    Dout = CA[7:0];
            REG_CA_HI:    Dout = CA[15:8];
            REG_REUA_LO:  Dout = reuaExt[7:0];
            REG_REUA_MID: Dout = reuaExt[15:8];
            REG_REUA_HI:  Dout = reuaExt[23:16];
            REG_LEN_LO:   Dout = len[7:0];
            REG_LEN_HI:   Dout = len[15:8];
            REG_IMASK:    Dout = {maskReg, 5'h1F};
            REG_ACTL:     Dout = {fixCa, fixReua, 6'h3F};
            default:      Dout = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_reu_regs.sv
// Self-checking bench for reu_regs: reset/readback table, directed transfer
// sequences and randomized traffic against a behavioural register model.
module tb_reu_regs;
    import reu_pkg::*;

    localparam int REUAW = 19;

    logic             PHI2 = 1'b1;
    logic             RegReset, RegCS, RegWE, RegRD, FF00Wr;
    logic [4:0]       RegA;
    logic [7:0]       Din, Dout;
    logic             DMA, IncCA, DecLen, IncREUA, XferEnd, SetEndOfBlock, SetVerifyErr;
    logic             Execute, Length1, Length2, nIRQ;
    logic [1:0]       XferType;
    logic [15:0]      CA;
    logic [REUAW-1:0] REUA;

    reu_regs #(.REUAW(REUAW), .BIGREU(1'b1)) dut (
        .PHI2(PHI2), .RegReset(RegReset), .RegCS(RegCS), .RegA(RegA),
        .RegWE(RegWE), .RegRD(RegRD), .Din(Din), .Dout(Dout), .FF00Wr(FF00Wr),
        .DMA(DMA), .IncCA(IncCA), .DecLen(DecLen), .IncREUA(IncREUA),
        .XferEnd(XferEnd), .SetEndOfBlock(SetEndOfBlock), .SetVerifyErr(SetVerifyErr),
        .Execute(Execute), .XferType(XferType), .Length1(Length1), .Length2(Length2),
        .CA(CA), .REUA(REUA), .nIRQ(nIRQ)
    );

    always #5 PHI2 = ~PHI2;

    int nTests = 0;
    int nFail  = 0;

    // Reference model state, kept as plain numbers and flags.
    int       mCa, mReua, mLen, sCa, sReua, sLen;
    bit       mCmd7, mAuto, mDis, mM7, mM6, mM5, mFixCa, mFixReua;
    bit       mIrq, mEob, mVerr, mPend, mExec;
    logic [1:0] mType;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int setByte(input int v, input int b, input int d);
        return (v & ~(255 << (8 * b))) | ((d & 255) << (8 * b));
    endfunction

    function automatic logic [7:0] mRead(input int r);
        case (r)
            0:  return {mIrq, mEob, mVerr, 1'b1, 4'h0};
            1:  return {mCmd7, 1'b1, mAuto, mDis, 2'b11, mType};
            2:  return 8'(mCa);
            3:  return 8'(mCa >> 8);
            4:  return 8'(mReua);
            5:  return 8'(mReua >> 8);
            6:  return 8'((mReua >> 16) | ~((1 << (REUAW - 16)) - 1));
            7:  return 8'(mLen);
            8:  return 8'(mLen >> 8);
            9:  return {mM7, mM6, mM5, 5'h1F};
            10: return {mFixCa, mFixReua, 6'h3F};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic modelEdge();
        bit wr, rd, cmdW, setX, auto0;
        int r;
        if (RegReset) begin
            mCa = 0; mReua = 0; mLen = 'hFFFF; sCa = 0; sReua = 0; sLen = 0;
            mCmd7 = 0; mAuto = 0; mDis = 1; mType = 2'b00;
            {mM7, mM6, mM5, mFixCa, mFixReua} = '0;
            {mIrq, mEob, mVerr, mPend, mExec} = '0;
            return;
        end
        r     = int'(RegA[3:0]);
        wr    = RegCS && RegWE && !DMA;
        rd    = RegCS && RegRD && (r == 0);
        cmdW  = wr && (r == 1);
        auto0 = mAuto;

        mEob  = SetEndOfBlock || (mEob && !rd);
        mVerr = SetVerifyErr || (mVerr && !rd);
        mIrq  = (mIrq && !rd) || (mM7 && ((mEob && mM6) || (mVerr && mM5)));

        setX  = (cmdW && Din[7] && Din[4]) || (FF00Wr && mPend && !cmdW);
        mExec = setX || (mExec && !DMA);
        if (cmdW) mPend = Din[7] && !Din[4];
        else if (FF00Wr || XferEnd) mPend = 0;

        if (wr) begin
            case (r)
                1: begin mCmd7 = Din[7]; mAuto = Din[5]; mDis = Din[4]; mType = Din[1:0]; end
                2, 3: begin mCa = setByte(mCa, r - 2, Din); sCa = setByte(sCa, r - 2, Din); end
                4, 5, 6: begin
                    mReua = setByte(mReua, r - 4, Din) & ((1 << REUAW) - 1);
                    sReua = setByte(sReua, r - 4, Din) & ((1 << REUAW) - 1);
                end
                7, 8: begin mLen = setByte(mLen, r - 7, Din); sLen = setByte(sLen, r - 7, Din); end
                9: {mM7, mM6, mM5} = Din[7:5];
                10: {mFixCa, mFixReua} = Din[7:6];
                default: ;
            endcase
        end
        if (IncCA && !mFixCa) mCa = (mCa + 1) % 65536;
        if (IncREUA && !mFixReua) mReua = (mReua + 1) % (1 << REUAW);
        if (DecLen) mLen = (mLen + 65535) % 65536;
        if (XferEnd) begin
            mCmd7 = 0;
            mDis  = 1;
            if (auto0) begin mCa = sCa; mReua = sReua; mLen = sLen; end
        end
    endtask

    task automatic checkAll();
        chk("CA", CA, mCa);
        chk("REUA", REUA, mReua);
        chk("Length1", Length1, mLen == 1);
        chk("Length2", Length2, mLen == 2);
        chk("XferType", XferType, mType);
        chk("nIRQ", nIRQ, !mIrq);
        chk("Execute", Execute, mExec);
        chk("Dout", Dout, mRead(int'(RegA[3:0])));
    endtask

    task automatic tick();
        modelEdge();
        @(negedge PHI2);
        #1;
        checkAll();
    endtask

    task automatic idle();
        {RegReset, RegCS, RegWE, RegRD, FF00Wr, DMA} = '0;
        {IncCA, DecLen, IncREUA, XferEnd, SetEndOfBlock, SetVerifyErr} = '0;
        Din = 8'h00;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        RegCS = 1; RegWE = 1; RegA = a; Din = d;
        tick();
        RegCS = 0; RegWE = 0;
    endtask

    task automatic peekChk(input string name, input logic [4:0] a, input logic [7:0] exp);
        RegA = a;
        tick();
        chk(name, Dout, exp);
    endtask

    task automatic readStatus();
        RegCS = 1; RegRD = 1; RegA = 5'h00;
        tick();
        RegCS = 0; RegRD = 0;
    endtask

    typedef struct {
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] expRd;
    } vec_t;

    vec_t       vecs[16];
    logic [7:0] resetExp[12];

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        resetExp = '{8'h10, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'hF8, 8'hFF, 8'hFF, 8'h1F, 8'h3F, 8'hFF};
        vecs = '{
            '{5'h02, 8'h34, 8'h34}, '{5'h13, 8'h12, 8'h12}, '{5'h04, 8'h45, 8'h45},
            '{5'h05, 8'h23, 8'h23}, '{5'h16, 8'hFF, 8'hFF}, '{5'h06, 8'h01, 8'hF9},
            '{5'h07, 8'h02, 8'h02}, '{5'h08, 8'h00, 8'h00}, '{5'h09, 8'hE0, 8'hFF},
            '{5'h09, 8'h40, 8'h5F}, '{5'h19, 8'h00, 8'h1F}, '{5'h0A, 8'h80, 8'hBF},
            '{5'h0A, 8'h00, 8'h3F}, '{5'h0B, 8'h5A, 8'hFF}, '{5'h01, 8'h03, 8'h4F},
            '{5'h00, 8'hFF, 8'h10}
        };

        idle();
        RegA = 5'h00;
        RegReset = 1;
        tick();
        RegReset = 0;
        chk("rst_nIRQ", nIRQ, 1);
        chk("rst_Execute", Execute, 0);
        for (int i = 0; i < 12; i++) peekChk($sformatf("rst_reg%0d", i), 5'(i), resetExp[i]);

        for (int i = 0; i < 16; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d", i), Dout, vecs[i].expRd);
        end

        // Immediate trigger, then one step of every counter.
        wr(5'h01, 8'h90);
        chk("imm_exec", Execute, 1);
        chk("imm_len2", Length2, 1);
        chk("imm_type", XferType, XFER_C64_TO_REU);
        DMA = 1;
        tick();
        chk("imm_exec_clr", Execute, 0);
        IncCA = 1; IncREUA = 1; DecLen = 1;
        tick();
        IncCA = 0; IncREUA = 0; DecLen = 0;
        chk("step_ca", CA, 16'h1235);
        chk("step_reua", REUA, 19'h12346);
        chk("step_len1", Length1, 1);
        XferEnd = 1;
        tick();
        XferEnd = 0; DMA = 0;
        peekChk("end_cmd", 5'h01, 8'h5C);

        // FF00-triggered transfer.
        FF00Wr = 1;
        tick();
        FF00Wr = 0;
        chk("ff00_unarmed", Execute, 0);
        wr(5'h01, 8'h81);
        chk("ff00_wait", Execute, 0);
        chk("ff00_type", XferType, XFER_REU_TO_C64);
        tick();
        tick();
        chk("ff00_still", Execute, 0);
        FF00Wr = 1;
        tick();
        FF00Wr = 0;
        chk("ff00_exec", Execute, 1);
        DMA = 1;
        tick();
        XferEnd = 1;
        tick();
        XferEnd = 0; DMA = 0;

        // Autoload restores counters at end of transfer.
        wr(5'h02, 8'h00); wr(5'h03, 8'h40);
        wr(5'h04, 8'h10); wr(5'h05, 8'h20); wr(5'h06, 8'h03);
        wr(5'h07, 8'h05); wr(5'h08, 8'h00);
        wr(5'h01, 8'hB0);
        DMA = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            IncCA = 1; IncREUA = 1; DecLen = 1;
            tick();
        end
        IncCA = 0; IncREUA = 0; DecLen = 0;
        chk("al_ca_moved", CA, 16'h4003);
        XferEnd = 1;
        tick();
        XferEnd = 0; DMA = 0;
        chk("al_ca", CA, 16'h4000);
        chk("al_reua", REUA, 19'h32010);
        peekChk("al_len", 5'h07, 8'h05);
        peekChk("al_cmd", 5'h01, 8'h7C);

        // Interrupt on VerifyErr, read-clear and set-wins.
        wr(5'h09, 8'hE0);
        SetVerifyErr = 1;
        tick();
        SetVerifyErr = 0;
        chk("irq_low", nIRQ, 0);
        peekChk("irq_status", 5'h00, 8'hB0);
        readStatus();
        peekChk("irq_cleared", 5'h00, 8'h10);
        chk("irq_high", nIRQ, 1);
        SetVerifyErr = 1;
        tick();
        RegCS = 1; RegRD = 1; RegA = 5'h00;
        tick();
        RegCS = 0; RegRD = 0; SetVerifyErr = 0;
        peekChk("irq_setwins", 5'h00, 8'hB0);
        chk("irq_setwins_n", nIRQ, 0);
        readStatus();

        // REUA wrap, then fix-REUA holds it.
        wr(5'h0A, 8'h00);
        wr(5'h04, 8'hFF); wr(5'h05, 8'hFF); wr(5'h06, 8'h07);
        DMA = 1; IncREUA = 1;
        tick();
        DMA = 0; IncREUA = 0;
        chk("reua_wrap", REUA, 19'h00000);
        wr(5'h04, 8'hFF); wr(5'h05, 8'hFF); wr(5'h06, 8'h07);
        wr(5'h0A, 8'h40);
        DMA = 1; IncREUA = 1;
        tick();
        DMA = 0; IncREUA = 0;
        chk("reua_fixed", REUA, 19'h7FFFF);

        // Reset in the middle of a transfer.
        wr(5'h0A, 8'h00);
        wr(5'h01, 8'h90);
        chk("rst_mid_exec", Execute, 1);
        RegReset = 1;
        tick();
        RegReset = 0;
        chk("rst_mid_clr", Execute, 0);
        chk("rst_mid_ca", CA, 16'h0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            idle();
            RegReset = ($urandom % 150) == 0;
            DMA      = $urandom % 2;
            RegCS    = $urandom % 2;
            RegWE    = $urandom % 2;
            RegRD    = $urandom % 2;
            RegA     = 5'($urandom);
            Din      = 8'($urandom);
            if (mExec) Din[7] = 1'b0;
            FF00Wr        = ($urandom % 4) == 0;
            SetEndOfBlock = ($urandom % 8) == 0;
            SetVerifyErr  = ($urandom % 8) == 0;
            if (DMA) begin
                IncCA   = $urandom % 2;
                IncREUA = $urandom % 2;
                DecLen  = $urandom % 2;
                XferEnd = ($urandom % 8) == 0;
            end
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
